// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
//   Shared definitions for the CPU control unit:
//     state_t        - control FSM states
//     instr_class_t  - instruction classes produced by instr_class_decode
//     OP_* / EXT_*   - primary opcode (instr[15:12]) and extended opcode
//                      (instr[7:4]) values the control unit distinguishes
//     ALU_*          - ALU operation codes that select PSR flag groups
//     PC_SEL_*       - next-PC source encodings
//     WB_SEL_*       - register write-back source encodings
//     ADDR_SEL_*     - memory address source encodings
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM_RD = 3'd3,
        ST_MEM_WR = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP   = 3'd0,
        CLS_ALU   = 3'd1,
        CLS_LOAD  = 3'd2,
        CLS_STOR  = 3'd3,
        CLS_JCOND = 3'd4,
        CLS_BCOND = 3'd5
    } instr_class_t;

    // Primary opcodes
    localparam logic [3:0] OP_REG_ALU = 4'b0000;
    localparam logic [3:0] OP_MEM_JMP = 4'b0100;
    localparam logic [3:0] OP_BCOND   = 4'b1100;

    // Extended opcodes under OP_MEM_JMP
    localparam logic [3:0] EXT_LOAD   = 4'b0000;
    localparam logic [3:0] EXT_STOR   = 4'b0100;
    localparam logic [3:0] EXT_JCOND  = 4'b1100;

    // ALU operations with flag side effects (ext for register form,
    // op for immediate form)
    localparam logic [3:0] ALU_ADD    = 4'b0101;
    localparam logic [3:0] ALU_SUB    = 4'b1001;
    localparam logic [3:0] ALU_CMP    = 4'b1011;

    // Next-PC source
    localparam logic [1:0] PC_SEL_INC  = 2'b00;
    localparam logic [1:0] PC_SEL_DISP = 2'b01;
    localparam logic [1:0] PC_SEL_REG  = 2'b10;

    // Write-back source
    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;

    // Memory address source
    localparam logic ADDR_SEL_PC  = 1'b0;
    localparam logic ADDR_SEL_REG = 1'b1;

    localparam logic [15:0] INSTR_HALT = 16'h0000;

    // Immediate-form ALU opcodes: 0001-0011 and 0101-1011
    function automatic logic is_imm_alu_op(input logic [3:0] op);
        return ((op >= 4'd1) && (op <= 4'd3)) || ((op >= 4'd5) && (op <= 4'd11));
    endfunction

endpackage

// File: rtl/instr_class_decode.sv
// ---------------------------------------------------------------------------
// instr_class_decode
//   Purely combinational instruction classifier for the control FSM.
//   Ports:
//     instr    in  16  instruction register contents
//     cls      out  3  instruction class (instr_class_t)
//     of_grp   out  1  ALU op updates the overflow flag group (ADD/SUB)
//     cmp_grp  out  1  ALU op is CMP: updates compare + zero groups and
//                      suppresses register write-back
//     is_halt  out  1  instruction is the all-zero HALT encoding
// ---------------------------------------------------------------------------
module instr_class_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [15:0]  instr,
    output instr_class_t cls,
    output logic         of_grp,
    output logic         cmp_grp,
    output logic         is_halt
);

    logic [3:0] op;
    logic [3:0] ext;
    logic [3:0] alu_code;

    assign op  = instr[15:12];
    assign ext = instr[7:4];

    always_comb begin
        cls      = CLS_NOP;
        alu_code = '0;
        of_grp   = 1'b0;
        cmp_grp  = 1'b0;
        is_halt  = (instr == INSTR_HALT);

        case (op)
            OP_REG_ALU: begin
                cls      = CLS_ALU;
                alu_code = ext;
            end
            OP_MEM_JMP: begin
                case (ext)
                    EXT_LOAD:  cls = CLS_LOAD;
                    EXT_STOR:  cls = CLS_STOR;
                    EXT_JCOND: cls = CLS_JCOND;
                    default:   cls = CLS_NOP;
                endcase
            end
            OP_BCOND: cls = CLS_BCOND;
            default: begin
                if (is_imm_alu_op(op)) begin
                    cls      = CLS_ALU;
                    alu_code = op;
                end
            end
        endcase

        if (cls == CLS_ALU) begin
            of_grp  = (alu_code == ALU_ADD) || (alu_code == ALU_SUB);
            cmp_grp = (alu_code == ALU_CMP);
        end

        // The all-zero word would otherwise decode as a register ALU op;
        // when it is not taken as HALT it must behave as a plain NOP.
        if (is_halt) begin
            cls     = CLS_NOP;
            of_grp  = 1'b0;
            cmp_grp = 1'b0;
        end
    end

endmodule

// File: rtl/cpu_control.sv
// ---------------------------------------------------------------------------
// cpu_control
//   Multi-cycle control FSM: FETCH -> DECODE -> EXEC [-> MEM_RD/MEM_WR]
//   with a terminal HALT state. All outputs are combinational from the
//   current state, instr, mem_ack and cond_met, and are forced low while
//   reset_n is low.
//   Parameter:
//     HALT_EN   1: instr 16'h0000 enters HALT; 0: it executes as a NOP
//   Ports:
//     clk       in   1  clock, rising edge
//     reset_n   in   1  asynchronous active-low reset
//     instr     in  16  instruction register contents
//     mem_ack   in   1  memory completes current request this cycle
//     cond_met  in   1  branch condition true
//     mem_req   out  1  memory request strobe
//     mem_we    out  1  memory write qualifier
//     addr_sel  out  1  address source: 0 = PC, 1 = Raddr
//     pc_en     out  1  PC load enable
//     instr_en  out  1  instruction register load enable
//     pc_sel    out  2  next PC: 00 PC+1, 01 PC+disp8, 10 Rtarget
//     rf_wr_en  out  1  register file write enable
//     wb_sel    out  1  write-back source: 0 = ALU, 1 = memory
//     cmp_f_en  out  1  compare flag group enable
//     of_f_en   out  1  overflow flag group enable
//     z_f_en    out  1  zero flag group enable
//     halted    out  1  high while in HALT
// ---------------------------------------------------------------------------
module cpu_control
    import cpu_ctrl_pkg::*;
#(
    parameter bit HALT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] instr,
    input  logic        mem_ack,
    input  logic        cond_met,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        pc_en,
    output logic        instr_en,
    output logic [1:0]  pc_sel,
    output logic        rf_wr_en,
    output logic        wb_sel,
    output logic        cmp_f_en,
    output logic        of_f_en,
    output logic        z_f_en,
    output logic        halted
);

    state_t       state;
    state_t       state_next;
    instr_class_t cls;
    logic         of_grp;
    logic         cmp_grp;
    logic         is_halt;

    instr_class_decode u_decode (
        .instr   (instr),
        .cls     (cls),
        .of_grp  (of_grp),
        .cmp_grp (cmp_grp),
        .is_halt (is_halt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = ADDR_SEL_PC;
        pc_en      = 1'b0;
        instr_en   = 1'b0;
        pc_sel     = PC_SEL_INC;
        rf_wr_en   = 1'b0;
        wb_sel     = WB_SEL_ALU;
        cmp_f_en   = 1'b0;
        of_f_en    = 1'b0;
        z_f_en     = 1'b0;
        halted     = 1'b0;

        case (state)
            ST_FETCH: begin
                mem_req  = 1'b1;
                addr_sel = ADDR_SEL_PC;
                if (mem_ack) begin
                    instr_en   = 1'b1;
                    state_next = ST_DECODE;
                end
            end

            ST_DECODE: begin
                if (HALT_EN && is_halt) begin
                    state_next = ST_HALT;
                end else begin
                    state_next = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_next = ST_FETCH;
                case (cls)
                    CLS_ALU: begin
                        rf_wr_en = !cmp_grp;
                        wb_sel   = WB_SEL_ALU;
                        pc_en    = 1'b1;
                        pc_sel   = PC_SEL_INC;
                        of_f_en  = of_grp;
                        cmp_f_en = cmp_grp;
                        z_f_en   = cmp_grp;
                    end
                    CLS_BCOND: begin
                        pc_en  = 1'b1;
                        pc_sel = cond_met ? PC_SEL_DISP : PC_SEL_INC;
                    end
                    CLS_JCOND: begin
                        pc_en  = 1'b1;
                        pc_sel = cond_met ? PC_SEL_REG : PC_SEL_INC;
                    end
                    CLS_LOAD: state_next = ST_MEM_RD;
                    CLS_STOR: state_next = ST_MEM_WR;
                    default: begin
                        pc_en  = 1'b1;
                        pc_sel = PC_SEL_INC;
                    end
                endcase
            end

            ST_MEM_RD: begin
                mem_req  = 1'b1;
                addr_sel = ADDR_SEL_REG;
                if (mem_ack) begin
                    rf_wr_en   = 1'b1;
                    wb_sel     = WB_SEL_MEM;
                    pc_en      = 1'b1;
                    pc_sel     = PC_SEL_INC;
                    state_next = ST_FETCH;
                end
            end

            ST_MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = ADDR_SEL_REG;
                if (mem_ack) begin
                    pc_en      = 1'b1;
                    pc_sel     = PC_SEL_INC;
                    state_next = ST_FETCH;
                end
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            default: state_next = ST_FETCH;
        endcase

        // The register already sits in FETCH during reset, but FETCH drives
        // mem_req; gate everything so nothing is requested until release.
        if (!reset_n) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            addr_sel = ADDR_SEL_PC;
            pc_en    = 1'b0;
            instr_en = 1'b0;
            pc_sel   = PC_SEL_INC;
            rf_wr_en = 1'b0;
            wb_sel   = WB_SEL_ALU;
            cmp_f_en = 1'b0;
            of_f_en  = 1'b0;
            z_f_en   = 1'b0;
            halted   = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_control.sv
// ---------------------------------------------------------------------------
// tb_cpu_control
//   Self-checking bench for cpu_control. Two instances share all inputs:
//   dut (HALT_EN=1) and dut_nh (HALT_EN=0). Output vectors are packed as
//   {mem_req, mem_we, addr_sel, pc_en, instr_en, pc_sel[1:0], rf_wr_en,
//    wb_sel, cmp_f_en, of_f_en, z_f_en, halted}.
// ---------------------------------------------------------------------------
module tb_cpu_control;

    localparam int K_ALU  = 0;
    localparam int K_LOAD = 1;
    localparam int K_STOR = 2;
    localparam int K_J    = 3;
    localparam int K_B    = 4;
    localparam int K_NOP  = 5;
    localparam int K_HALT = 6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] instr;
    logic        mem_ack;
    logic        cond_met;

    logic        mem_req, mem_we, addr_sel, pc_en, instr_en;
    logic [1:0]  pc_sel;
    logic        rf_wr_en, wb_sel, cmp_f_en, of_f_en, z_f_en, halted;

    logic        n_mem_req, n_mem_we, n_addr_sel, n_pc_en, n_instr_en;
    logic [1:0]  n_pc_sel;
    logic        n_rf_wr_en, n_wb_sel, n_cmp_f_en, n_of_f_en, n_z_f_en, n_halted;

    logic [12:0] obs;
    logic [12:0] obs_nh;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cpu_control #(.HALT_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .instr(instr), .mem_ack(mem_ack),
        .cond_met(cond_met), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .pc_en(pc_en), .instr_en(instr_en),
        .pc_sel(pc_sel), .rf_wr_en(rf_wr_en), .wb_sel(wb_sel),
        .cmp_f_en(cmp_f_en), .of_f_en(of_f_en), .z_f_en(z_f_en),
        .halted(halted)
    );

    cpu_control #(.HALT_EN(1'b0)) dut_nh (
        .clk(clk), .reset_n(reset_n), .instr(instr), .mem_ack(mem_ack),
        .cond_met(cond_met), .mem_req(n_mem_req), .mem_we(n_mem_we),
        .addr_sel(n_addr_sel), .pc_en(n_pc_en), .instr_en(n_instr_en),
        .pc_sel(n_pc_sel), .rf_wr_en(n_rf_wr_en), .wb_sel(n_wb_sel),
        .cmp_f_en(n_cmp_f_en), .of_f_en(n_of_f_en), .z_f_en(n_z_f_en),
        .halted(n_halted)
    );

    assign obs    = {mem_req, mem_we, addr_sel, pc_en, instr_en, pc_sel,
                     rf_wr_en, wb_sel, cmp_f_en, of_f_en, z_f_en, halted};
    assign obs_nh = {n_mem_req, n_mem_we, n_addr_sel, n_pc_en, n_instr_en, n_pc_sel,
                     n_rf_wr_en, n_wb_sel, n_cmp_f_en, n_of_f_en, n_z_f_en, n_halted};

    // Build an expected output vector from named fields
    function automatic logic [12:0] ev(input bit req, input bit we, input bit asel,
                                       input bit pcen, input bit ien, input logic [1:0] psel,
                                       input bit rfw, input bit wbs, input bit cmpf,
                                       input bit off, input bit zf, input bit hlt);
        return {req, we, asel, pcen, ien, psel, rfw, wbs, cmpf, off, zf, hlt};
    endfunction

    // Reference classification straight from the instruction-set table
    function automatic int model_kind(input logic [15:0] i, input bit halt_en);
        int op;
        int ext;
        op  = int'(i) / 4096;
        ext = (int'(i) / 16) % 16;
        if (i == 16'h0000) return halt_en ? K_HALT : K_NOP;
        if (op == 0) return K_ALU;
        if ((op >= 1 && op <= 3) || (op >= 5 && op <= 11)) return K_ALU;
        if (op == 4) begin
            if (ext == 0)  return K_LOAD;
            if (ext == 4)  return K_STOR;
            if (ext == 12) return K_J;
            return K_NOP;
        end
        if (op == 12) return K_B;
        return K_NOP;
    endfunction

    // ALU op code that selects flag groups: ext for register form, op otherwise
    function automatic int model_alu_code(input logic [15:0] i);
        int op;
        op = int'(i) / 4096;
        return (op == 0) ? (int'(i) / 16) % 16 : op;
    endfunction

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        mem_ack  = 1'b0;
        cond_met = 1'b0;
        instr    = 16'h0000;
        adv();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        mem_ack  = 1'b1;
        instr    = 16'h4000;
        cond_met = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL reset_hold got=%b exp=%b", obs, 13'd0);
        end
        checks++;
        if (obs_nh !== 13'd0) begin
            errors++;
            $display("FAIL reset_hold_nh got=%b exp=%b", obs_nh, 13'd0);
        end
        adv();
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== ev(1,0,0,0,1,2'b00,0,0,0,0,0,0)) begin
            errors++;
            $display("FAIL reset_first_fetch got=%b exp=%b", obs, ev(1,0,0,0,1,2'b00,0,0,0,0,0,0));
        end
        adv();
    endtask

    task automatic test_add();
        do_reset();
        instr   = 16'h0250;
        mem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== ev(1,0,0,0,1,2'b00,0,0,0,0,0,0)) begin
            errors++;
            $display("FAIL add_c1 got=%b exp=%b", obs, ev(1,0,0,0,1,2'b00,0,0,0,0,0,0));
        end
        adv();
        @(negedge clk);
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL add_c2 got=%b exp=%b", obs, 13'd0);
        end
        adv();
        @(negedge clk);
        checks++;
        if (obs !== ev(0,0,0,1,0,2'b00,1,0,0,1,0,0)) begin
            errors++;
            $display("FAIL add_c3 got=%b exp=%b", obs, ev(0,0,0,1,0,2'b00,1,0,0,1,0,0));
        end
        adv();
    endtask

    task automatic test_cmp();
        logic [15:0] list [2];
        list[0] = 16'h01B3;
        list[1] = 16'hB123;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            instr   = list[k];
            mem_ack = 1'b1;
            adv();
            adv();
            @(negedge clk);
            checks++;
            if (obs !== ev(0,0,0,1,0,2'b00,0,0,1,0,1,0)) begin
                errors++;
                $display("FAIL cmp_exec instr=%h got=%b exp=%b", list[k], obs,
                         ev(0,0,0,1,0,2'b00,0,0,1,0,1,0));
            end
            adv();
        end
    endtask

    task automatic test_bcond();
        for (int c = 1; c >= 0; c--) begin
            do_reset();
            instr   = 16'hC0FE;
            mem_ack = 1'b1;
            adv();
            adv();
            cond_met = c[0];
            @(negedge clk);
            checks++;
            if (obs !== ev(0,0,0,1,0,(c == 1) ? 2'b01 : 2'b00,0,0,0,0,0,0)) begin
                errors++;
                $display("FAIL bcond cond=%0d got=%b exp=%b", c, obs,
                         ev(0,0,0,1,0,(c == 1) ? 2'b01 : 2'b00,0,0,0,0,0,0));
            end
            adv();
        end
    endtask

    task automatic test_load_wait();
        int req_cycles;
        do_reset();
        instr   = 16'h4302;
        mem_ack = 1'b1;
        adv();
        adv();
        @(negedge clk);
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL load_exec got=%b exp=%b", obs, 13'd0);
        end
        adv();
        req_cycles = 0;
        for (int w = 0; w < 4; w++) begin
            mem_ack = (w == 3);
            @(negedge clk);
            if (mem_req === 1'b1) req_cycles++;
            checks++;
            if (obs !== ((w == 3) ? ev(1,0,1,1,0,2'b00,1,1,0,0,0,0)
                                  : ev(1,0,1,0,0,2'b00,0,0,0,0,0,0))) begin
                errors++;
                $display("FAIL load_memrd w=%0d got=%b", w, obs);
            end
            adv();
        end
        mem_ack = 1'b0;
        checks++;
        if (req_cycles != 4) begin
            errors++;
            $display("FAIL load_req_len got=%0d exp=4", req_cycles);
        end
        @(negedge clk);
        checks++;
        if (obs !== ev(1,0,0,0,0,2'b00,0,0,0,0,0,0)) begin
            errors++;
            $display("FAIL load_refetch got=%b exp=%b", obs, ev(1,0,0,0,0,2'b00,0,0,0,0,0,0));
        end
        adv();
    endtask

    task automatic test_reset_memwr();
        do_reset();
        instr   = 16'h4145;
        mem_ack = 1'b1;
        adv();
        adv();
        adv();
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== ev(1,1,1,0,0,2'b00,0,0,0,0,0,0)) begin
            errors++;
            $display("FAIL memwr_wait got=%b exp=%b", obs, ev(1,1,1,0,0,2'b00,0,0,0,0,0,0));
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL memwr_async_drop got=%b%b exp=00", mem_req, mem_we);
        end
        adv();
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL memwr_reset_hold got=%b exp=%b", obs, 13'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== ev(1,0,0,0,0,2'b00,0,0,0,0,0,0)) begin
            errors++;
            $display("FAIL memwr_restart got=%b exp=%b", obs, ev(1,0,0,0,0,2'b00,0,0,0,0,0,0));
        end
        adv();
    endtask

    task automatic test_halt();
        do_reset();
        instr   = 16'h0000;
        mem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== ev(1,0,0,0,1,2'b00,0,0,0,0,0,0)) begin
            errors++;
            $display("FAIL halt_c1 got=%b exp=%b", obs, ev(1,0,0,0,1,2'b00,0,0,0,0,0,0));
        end
        adv();
        adv();
        @(negedge clk);
        checks++;
        if (obs !== ev(0,0,0,0,0,2'b00,0,0,0,0,0,1)) begin
            errors++;
            $display("FAIL halt_c3 got=%b exp=%b", obs, ev(0,0,0,0,0,2'b00,0,0,0,0,0,1));
        end
        checks++;
        if (obs_nh !== ev(0,0,0,1,0,2'b00,0,0,0,0,0,0)) begin
            errors++;
            $display("FAIL nohalt_nop got=%b exp=%b", obs_nh, ev(0,0,0,1,0,2'b00,0,0,0,0,0,0));
        end
        adv();
        checks++;
        if (n_mem_req !== 1'b1) begin
            errors++;
            $display("FAIL nohalt_refetch got=%b exp=1", n_mem_req);
        end
        for (int k = 0; k < 5; k++) begin
            cond_met = 1'($urandom);
            @(negedge clk);
            checks++;
            if (obs !== ev(0,0,0,0,0,2'b00,0,0,0,0,0,1)) begin
                errors++;
                $display("FAIL halt_stay k=%0d got=%b", k, obs);
            end
            adv();
        end
        do_reset();
        instr   = 16'h1234;
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== ev(1,0,0,0,0,2'b00,0,0,0,0,0,0)) begin
            errors++;
            $display("FAIL halt_exit got=%b exp=%b", obs, ev(1,0,0,0,0,2'b00,0,0,0,0,0,0));
        end
        adv();
    endtask

    task automatic test_random(input int n);
        logic [15:0] ins;
        logic [12:0] exp;
        int          k;
        int          code;
        int          d;
        bit          c;
        bit          of_g;
        bit          cz_g;
        do_reset();
        for (int t = 0; t < n; t++) begin
            ins = 16'($urandom);
            case ($urandom_range(0, 5))
                0: begin ins[15:12] = 4'h4; ins[7:4] = 4'h0; end
                1: begin ins[15:12] = 4'h4; ins[7:4] = 4'h4; end
                2: begin ins[15:12] = 4'h4; ins[7:4] = 4'hC; end
                3: ins[15:12] = 4'hC;
                4: ins[15:12] = 4'h0;
                default: ;
            endcase
            if (ins == 16'h0000) ins = 16'h0001;
            k    = model_kind(ins, 1'b1);
            code = model_alu_code(ins);
            of_g = (k == K_ALU) && (code == 5 || code == 9);
            cz_g = (k == K_ALU) && (code == 11);

            d = $urandom_range(0, 2);
            for (int w = 0; w <= d; w++) begin
                instr    = 16'($urandom);
                mem_ack  = (w == d);
                cond_met = 1'($urandom);
                @(negedge clk);
                checks++;
                if (obs !== ev(1,0,0,0,(w == d),2'b00,0,0,0,0,0,0)) begin
                    errors++;
                    $display("FAIL rand_fetch instr=%h w=%0d got=%b", ins, w, obs);
                end
                adv();
            end

            instr    = ins;
            mem_ack  = 1'($urandom);
            cond_met = 1'($urandom);
            @(negedge clk);
            checks++;
            if (obs !== 13'd0) begin
                errors++;
                $display("FAIL rand_decode instr=%h got=%b exp=0", ins, obs);
            end
            adv();

            c        = 1'($urandom);
            cond_met = c;
            mem_ack  = 1'($urandom);
            case (k)
                K_ALU:  exp = ev(0,0,0,1,0,2'b00,!cz_g,0,cz_g,of_g,cz_g,0);
                K_B:    exp = ev(0,0,0,1,0,c ? 2'b01 : 2'b00,0,0,0,0,0,0);
                K_J:    exp = ev(0,0,0,1,0,c ? 2'b10 : 2'b00,0,0,0,0,0,0);
                K_LOAD: exp = 13'd0;
                K_STOR: exp = 13'd0;
                default: exp = ev(0,0,0,1,0,2'b00,0,0,0,0,0,0);
            endcase
            @(negedge clk);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rand_exec instr=%h cond=%0d got=%b exp=%b", ins, c, obs, exp);
            end
            adv();

            if (k == K_LOAD || k == K_STOR) begin
                d = $urandom_range(0, 3);
                for (int w = 0; w <= d; w++) begin
                    mem_ack  = (w == d);
                    cond_met = 1'($urandom);
                    if (w == d)
                        exp = (k == K_LOAD) ? ev(1,0,1,1,0,2'b00,1,1,0,0,0,0)
                                            : ev(1,1,1,1,0,2'b00,0,0,0,0,0,0);
                    else
                        exp = ev(1,(k == K_STOR),1,0,0,2'b00,0,0,0,0,0,0);
                    @(negedge clk);
                    checks++;
                    if (obs !== exp) begin
                        errors++;
                        $display("FAIL rand_mem instr=%h w=%0d got=%b exp=%b", ins, w, obs, exp);
                    end
                    adv();
                end
            end
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        instr    = 16'h0000;
        mem_ack  = 1'b0;
        cond_met = 1'b0;
        #1;
        test_reset();
        test_add();
        test_cmp();
        test_bcond();
        test_load_wait();
        test_reset_memwr();
        test_random(200);
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_control.md
CPU_CONTROL -- requirements
Module: cpu_control

Interface
REQ-001 Parameter: HALT_EN, default 1, 1 = instruction 16'h0000 enters HALT; 0 = it executes as a NOP.
REQ-002 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: instr  input  16  current instruction register contents.
REQ-005 Port: mem_ack  input  1  memory completes the current request this cycle.
REQ-006 Port: cond_met  input  1  branch condition true, evaluated from PSR by downstream logic.
REQ-007 Port: mem_req / mem_we  output  1 each  memory request strobe / write qualifier.
REQ-008 Port: addr_sel  output  1  memory address source: 0 = PC, 1 = register Raddr.
REQ-009 Port: pc_en, instr_en  output  1 each  PC and instruction-register load enables.
REQ-010 Port: pc_sel  output  2  next-PC source: 00 = PC+1, 01 = PC+disp8, 10 = Rtarget.
REQ-011 Port: rf_wr_en  output  1  register-file write enable.
REQ-012 Port: wb_sel  output  1  write-back source: 0 = ALU, 1 = memory.
REQ-013 Port: cmp_f_en, of_f_en, z_f_en  output  1 each  PSR flag-group enables.
REQ-014 Port: halted  output  1  high while in HALT.

Function
REQ-015 FSM states: FETCH, DECODE, EXEC, MEM_RD, MEM_WR, HALT.
REQ-016 All outputs SHALL be combinational functions of state, instr, mem_ack and cond_met; every output is 0 unless stated below.
REQ-017 FETCH: mem_req=1, addr_sel=0; on mem_ack, instr_en=1 and next state DECODE; otherwise hold FETCH indefinitely.
REQ-018 DECODE: one cycle with no outputs asserted; next state EXEC, or HALT if HALT_EN=1 and instr=16'h0000.
REQ-019 Instruction classes: op=instr[15:12]; ext=instr[7:4].
REQ-020 Classes: op 0000 = register ALU; op 0100 with ext 0000 = LOAD, ext 0100 = STOR, ext 1100 = Jcond; op 1100 = Bcond; op 0001-0011 and 0101-1011 = immediate ALU; every other encoding = NOP.
REQ-021 EXEC, ALU class: rf_wr_en=1, wb_sel=0, pc_en=1, pc_sel=00; next state FETCH.
REQ-022 Flag enables in EXEC: ext/op ADD (0101) or SUB (1001) -> of_f_en=1; CMP (1011) -> cmp_f_en=1 and z_f_en=1; CMP SHALL NOT assert rf_wr_en.
REQ-023 EXEC, Bcond: pc_en=1, pc_sel = cond_met ? 01 : 00; next state FETCH.
REQ-024 EXEC, Jcond: pc_en=1, pc_sel = cond_met ? 10 : 00; next state FETCH.
REQ-025 EXEC, LOAD: next state MEM_RD, no outputs. EXEC, STOR: next state MEM_WR, no outputs. EXEC, NOP: pc_en=1, pc_sel=00; next state FETCH.
REQ-026 MEM_RD: mem_req=1, addr_sel=1; on mem_ack, rf_wr_en=1, wb_sel=1, pc_en=1, pc_sel=00, next state FETCH.
REQ-027 MEM_WR: mem_req=1, mem_we=1, addr_sel=1; on mem_ack, pc_en=1, pc_sel=00, next state FETCH.
REQ-028 mem_ack SHALL be ignored in DECODE, EXEC and HALT.
REQ-029 mem_req SHALL stay continuously high from the request cycle through the ack cycle.
REQ-030 HALT: halted=1, no other outputs; exits only on reset.
REQ-031 Latency: ALU, branch and NOP instructions take 3 cycles with zero-wait memory; LOAD and STOR take 4 cycles.

Reset
REQ-032 reset_n low SHALL force state FETCH asynchronously and hold all enables low for as long as reset_n is low, including mid-transaction (mem_req drops immediately).
REQ-033 The first mem_req SHALL occur in the first cycle after reset_n deasserts.

Structure
REQ-034 Package cpu_ctrl_pkg SHALL hold the state enum, op/ext constants, and the pc_sel and wb_sel encodings.
REQ-035 Combinational sub-module instr_class_decode SHALL map instr to a class code plus flag-group bits; cpu_control instantiates it once.

Verification
REQ-036 Reset, then instr=16'h0000 with HALT_EN=1 and mem_ack tied high -> halted=1 on cycle 3, and no further mem_req.
REQ-037 ADD (op 0000, ext 0101) with zero-wait ack -> instr_en at cycle 1; rf_wr_en, of_f_en and pc_en with pc_sel=00 at cycle 3.
REQ-038 CMP (ext 1011) -> cmp_f_en=1 and z_f_en=1, rf_wr_en=0 in EXEC.
REQ-039 Bcond (op 1100) with cond_met=1 -> pc_sel=01; with cond_met=0 -> pc_sel=00.
REQ-040 LOAD with mem_ack delayed 3 cycles in MEM_RD -> mem_req held high for 4 cycles; rf_wr_en=1 and wb_sel=1 only in the ack cycle.
REQ-041 reset_n pulsed low during MEM_WR wait -> mem_req and mem_we drop in the same cycle, FSM restarts in FETCH.
